field_line_clear: RTL and testbench

Reads back the locked playfield after a piece has been merged into it and removes every full row. Surviving rows drop down, and empty rows are inserted at the top. Sits between the merge stage and the background register: the merged 400-bit field goes in, and the compacted field plus a cleared-line count come out. Sequential row-at-a-time engine with a start/busy/done handshake.

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/field_row_mux.sv | 21 ++
 rtl/field_line_clear.sv | 145 ++++++++++++++
 tb/tb_field_line_clear.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared playfield geometry, line-clear FSM state type and
// line-clear score increments.
//   FIELD_W / FIELD_H / FIELD_BITS : playfield geometry (row 0 = top)
//   lc_state_t                     : field_line_clear engine states
//   score_incr()                   : score increment for a given line count
package tetris_pkg;

    localparam int FIELD_W    = 20;
    localparam int FIELD_H    = 20;
    localparam int FIELD_BITS = FIELD_W * FIELD_H;

    localparam logic [15:0] SCORE_1 = 16'd40;
    localparam logic [15:0] SCORE_2 = 16'd100;
    localparam logic [15:0] SCORE_3 = 16'd300;
    localparam logic [15:0] SCORE_4 = 16'd1200;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FILL,
        S_DONE
    } lc_state_t;

    function automatic logic [15:0] score_incr(input logic [4:0] n);
        logic [15:0] v;
        case (n)
            5'd0:    v = '0;
            5'd1:    v = SCORE_1;
            5'd2:    v = SCORE_2;
            5'd3:    v = SCORE_3;
            default: v = SCORE_4;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/field_row_mux.sv
// field_row_mux: combinational row extractor.
//   field : FIELD_W*FIELD_H-bit playfield, bit = row*FIELD_W + col
//   idx   : row index
//   row   : FIELD_W bits of row idx
//   full  : row idx is all ones
module field_row_mux #(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20
) (
    input  logic [FIELD_W*FIELD_H-1:0] field,
    input  logic [4:0]                 idx,
    output logic [FIELD_W-1:0]         row,
    output logic                       full
);

    always_comb begin
        row  = field[idx*FIELD_W +: FIELD_W];
        full = &row;
    end

endmodule

// File: rtl/field_line_clear.sv
// field_line_clear: removes full rows from a merged playfield, one row per
// cycle, dropping surviving rows down and refilling empty rows at the top.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : one-cycle request, accepted only in IDLE
//   field_in   : merged field, bit = row*FIELD_W + col, row 0 = top
//   busy       : operation in progress (cycle after accept until DONE exits)
//   done       : one-cycle pulse, field_out/lines valid
//   field_out  : compacted field, held until the next operation completes
//   lines      : full rows removed by the last operation
//   score      : accumulated score, only when LINE_CLEAR_SCORE_EN is defined
module field_line_clear
    import tetris_pkg::*;
#(
    parameter int FIELD_W = tetris_pkg::FIELD_W,
    parameter int FIELD_H = tetris_pkg::FIELD_H
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [FIELD_W*FIELD_H-1:0] field_in,
    output logic                       busy,
    output logic                       done,
    output logic [FIELD_W*FIELD_H-1:0] field_out,
    output logic [4:0]                 lines
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]                score
`endif
);

    localparam int BITS = FIELD_W * FIELD_H;

    lc_state_t          state;
    logic [BITS-1:0]    src;
    logic [BITS-1:0]    work;
    logic [BITS-1:0]    work_nxt;
    logic [4:0]         rd;
    logic [4:0]         wr;
    logic [4:0]         cnt;
    logic [4:0]         cnt_nxt;
    logic [FIELD_W-1:0] src_row;
    logic               src_full;
    logic               finish;

    field_row_mux #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_src_mux (
        .field (src),
        .idx   (rd),
        .row   (src_row),
        .full  (src_full)
    );

    // Next work/cnt are formed combinationally so that the final row write
    // and the outputs can be captured on the same edge that enters DONE.
    always_comb begin
        work_nxt = work;
        cnt_nxt  = cnt;
        finish   = 1'b0;
        case (state)
            S_SCAN: begin
                if (src_full)
                    cnt_nxt = 5'(cnt + 5'd1);
                else
                    work_nxt[wr*FIELD_W +: FIELD_W] = src_row;
                finish = (rd == 5'd0) && (cnt_nxt == 5'd0);
            end
            S_FILL: begin
                work_nxt[wr*FIELD_W +: FIELD_W] = '0;
                finish = (wr == 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            src       <= '0;
            work      <= '0;
            rd        <= '0;
            wr        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            field_out <= '0;
            lines     <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            score     <= '0;
`endif
        end else begin
            work <= work_nxt;
            cnt  <= cnt_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src   <= field_in;
                        rd    <= 5'(FIELD_H - 1);
                        wr    <= 5'(FIELD_H - 1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // wr holds at 0 after the last write instead of wrapping
                    if (!src_full && wr != 5'd0)
                        wr <= wr - 5'd1;
                    if (rd == 5'd0) begin
                        if (cnt_nxt != 5'd0)
                            state <= S_FILL;
                    end else begin
                        rd <= rd - 5'd1;
                    end
                end
                S_FILL: begin
                    if (wr != 5'd0)
                        wr <= wr - 5'd1;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (finish) begin
                state     <= S_DONE;
                done      <= 1'b1;
                field_out <= work_nxt;
                lines     <= cnt_nxt;
`ifdef LINE_CLEAR_SCORE_EN
                begin
                    logic [16:0] sum;
                    sum   = {1'b0, score} + {1'b0, score_incr(cnt_nxt)};
                    score <= sum[16] ? 16'hFFFF : sum[15:0];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_field_line_clear.sv
// tb_field_line_clear: table-driven scoreboard bench for field_line_clear.
// Build with +define+LINE_CLEAR_SCORE_EN to also check the score port.
module tb_field_line_clear;

    localparam int W = 20;
    localparam int H = 20;
    localparam int B = W * H;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [B-1:0] field_in;
    logic         busy;
    logic         done;
    logic [B-1:0] field_out;
    logic [4:0]   lines;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]  score;
`endif

    field_line_clear #(.FIELD_W(W), .FIELD_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .field_in  (field_in),
        .busy      (busy),
        .done      (done),
        .field_out (field_out),
        .lines     (lines)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score     (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [B-1:0] fin;
        logic [B-1:0] fexp;
        logic [4:0]   lexp;
    } vec_t;

    typedef struct {
        logic [B-1:0] fexp;
        logic [4:0]   lexp;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_score = '0;

    function automatic logic [B-1:0] with_row(input logic [B-1:0] f, input int r,
                                              input logic [W-1:0] v);
        logic [B-1:0] t;
        t = f;
        t[r*W +: W] = v;
        return t;
    endfunction

    // Reference: collect surviving rows from the bottom upwards.
    function automatic void model(input logic [B-1:0] f, output logic [B-1:0] r,
                                  output logic [4:0] n);
        int w;
        logic [W-1:0] row;
        r = '0;
        n = '0;
        w = H - 1;
        for (int i = H - 1; i >= 0; i--) begin
            row = f[i*W +: W];
            if (row == {W{1'b1}}) n++;
            else begin
                r[w*W +: W] = row;
                w--;
            end
        end
    endfunction

    function automatic logic [15:0] incr(input logic [4:0] n);
        case (n)
            5'd0:    return 16'd0;
            5'd1:    return 16'd40;
            5'd2:    return 16'd100;
            5'd3:    return 16'd300;
            default: return 16'd1200;
        endcase
    endfunction

    task automatic chk(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for done (latency counted in edges after the accept edge), then
    // pops the scoreboard and compares.
    task automatic wait_done(input string name);
        int   n;
        exp_t e;
        logic [16:0] s;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk({name, " done_seen"}, B'(done), B'(1));
        chk({name, " latency"}, B'(n), B'(H + int'(e.lexp)));
        chk({name, " lines"}, B'(lines), B'(e.lexp));
        chk({name, " field_out"}, field_out, e.fexp);
        s = {1'b0, exp_score} + {1'b0, incr(e.lexp)};
        exp_score = s[16] ? 16'hFFFF : s[15:0];
`ifdef LINE_CLEAR_SCORE_EN
        chk({name, " score"}, B'(score), B'(exp_score));
`endif
    endtask

    task automatic run_op(input string name, input logic [B-1:0] f, input logic [B-1:0] fe,
                          input logic [4:0] le);
        exp_t e;
        @(negedge clk);
        field_in = f;
        start    = 1'b1;
        e.fexp = fe;
        e.lexp = le;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " busy_on"}, B'(busy), B'(1));
        wait_done(name);
        @(posedge clk); #1;
        chk({name, " done_off"}, B'(done), B'(0));
        chk({name, " busy_off"}, B'(busy), B'(0));
        chk({name, " field_hold"}, field_out, fe);
    endtask

    initial begin
        logic [B-1:0] f;
        logic [B-1:0] fe;
        logic [4:0]   le;
        exp_t         e;

        rst_n    = 1'b0;
        start    = 1'b0;
        field_in = '0;

        // Directed cases with hand-derived expectations.
        tbl[0].fin = '0; tbl[0].fexp = '0; tbl[0].lexp = 5'd0;

        f = with_row('0, 19, '1);
        f = with_row(f, 18, 20'h00001);
        tbl[1].fin = f; tbl[1].fexp = with_row('0, 19, 20'h00001); tbl[1].lexp = 5'd1;

        f = '0;
        for (int r = 16; r < 20; r++) f = with_row(f, r, '1);
        f = with_row(f, 15, 20'hABCDE);
        tbl[2].fin = f; tbl[2].fexp = with_row('0, 19, 20'hABCDE); tbl[2].lexp = 5'd4;

        f = '0; fe = '0;
        for (int r = 0; r < 20; r++) f = with_row(f, r, (r % 2) ? '1 : 20'h00001);
        for (int r = 10; r < 20; r++) fe = with_row(fe, r, 20'h00001);
        tbl[3].fin = f; tbl[3].fexp = fe; tbl[3].lexp = 5'd10;

        // Random fields with roughly 30% full rows.
        for (int k = 4; k < 7; k++) begin
            f = '0;
            for (int r = 0; r < H; r++)
                f = with_row(f, r, ($urandom_range(0, 9) < 3) ? '1 : W'($urandom));
            tbl[k].fin = f;
            model(f, fe, le);
            tbl[k].fexp = fe;
            tbl[k].lexp = le;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", B'(busy), B'(0));
        chk("reset done", B'(done), B'(0));
        chk("reset field_out", field_out, '0);
        chk("reset lines", B'(lines), B'(0));
`ifdef LINE_CLEAR_SCORE_EN
        chk("reset score", B'(score), B'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++)
            run_op($sformatf("vec%0d", k), tbl[k].fin, tbl[k].fexp, tbl[k].lexp);

        // Start held high throughout; field_in changes after acceptance.
        @(negedge clk);
        field_in = '0;
        start    = 1'b1;
        e.fexp = '0; e.lexp = 5'd0;
        sb.push_back(e);
        @(posedge clk); #1;
        field_in = '1;
        wait_done("hold1");
        @(posedge clk); #1;
        chk("hold done_cycle_ignored", B'(busy), B'(0));
        chk("hold single_done", B'(done), B'(0));
        e.fexp = '0; e.lexp = 5'd20;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("hold reaccept", B'(busy), B'(1));
        start = 1'b0;
        wait_done("hold2");
        @(posedge clk); #1;

        // Leave a nonzero result, then reset in SCAN cycle 7 of a 3-line clear.
        run_op("pre_rst", tbl[1].fin, tbl[1].fexp, tbl[1].lexp);
        f = '0;
        for (int r = 17; r < 20; r++) f = with_row(f, r, '1);
        f = with_row(f, 16, 20'h5A5A5);
        @(negedge clk);
        field_in = f;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", B'(busy), B'(0));
        chk("midrst done", B'(done), B'(0));
        chk("midrst field_out", field_out, '0);
        chk("midrst lines", B'(lines), B'(0));
`ifdef LINE_CLEAR_SCORE_EN
        chk("midrst score", B'(score), B'(0));
`endif
        exp_score = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", f, with_row('0, 19, 20'h5A5A5), 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
